bus_reader: RTL and testbench

BUS_READER -- requirements
Module: bus_reader

---
 rtl/bus_reader_pkg.sv | 8 +
 rtl/bus_reader_sync_fifo.sv | 73 +++++++
 rtl/bus_reader.sv | 69 ++++++
 tb/tb_bus_reader.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/bus_reader_pkg.sv
// Shared bus package: default bus width and capture FIFO depth used by the
// tri-state bus buffer and by bus_reader.
package bus_reader_pkg;

  localparam int BUS_WIDTH  = 8;
  localparam int FIFO_DEPTH = 4;

endpackage

// File: rtl/bus_reader_sync_fifo.sv
// sync_fifo: single-clock FIFO holding the storage array and read/write pointers.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   push/push_data write request and data
//   pop_req        read request; ignored while empty
//   head           oldest entry (don't-care while valid is low)
//   valid          FIFO non-empty
//   count          occupancy 0..DEPTH
//   full           count equals DEPTH
//   overflow       push this cycle is being dropped (full with no pop)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_req,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    occ;
  logic             do_pop;
  logic             do_push;

  // A push into a full FIFO still succeeds when a pop frees a slot in the
  // same cycle.
  always_comb begin
    do_pop   = pop_req && (occ != '0);
    do_push  = push && ((occ != FULL_COUNT) || do_pop);
    overflow = push && (occ == FULL_COUNT) && !do_pop;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign valid = (occ != '0);
  assign full  = (occ == FULL_COUNT);
  assign count = occ;

endmodule

// File: rtl/bus_reader.sv
// bus_reader: captures values from a shared tri-state bus into a FIFO.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus, bus_en           shared bus value and its driven/valid flag
//   ld                    capture request for this cycle
//   out_data, out_valid   FIFO head and non-empty flag
//   out_ready             consumer accepts out_data this cycle
//   count, full           occupancy and full flag
//   err_float             sticky: ld while bus not driven
//   err_ovf               sticky: capture dropped because FIFO full
//   clr_err               synchronous clear of both sticky flags (set wins)
module bus_reader
  import bus_reader_pkg::*;
#(
  parameter int WIDTH = BUS_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       bus,
  input  logic                   bus_en,
  input  logic                   ld,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   err_float,
  output logic                   err_ovf,
  input  logic                   clr_err
);

  logic capture;
  logic float_evt;
  logic overflow;

  always_comb begin
    capture   = ld && bus_en;
    float_evt = ld && !bus_en;
  end

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (capture),
    .push_data (bus),
    .pop_req   (out_ready),
    .head      (out_data),
    .valid     (out_valid),
    .count     (count),
    .full      (full),
    .overflow  (overflow)
  );

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_float <= 1'b0;
      err_ovf   <= 1'b0;
    end else begin
      err_float <= float_evt || (err_float && !clr_err);
      err_ovf   <= overflow  || (err_ovf   && !clr_err);
    end
  end

endmodule

// File: tb/tb_bus_reader.sv
module tb_bus_reader;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] bus;
  logic         bus_en;
  logic         ld;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic [2:0]   count;
  logic         full;
  logic         err_float;
  logic         err_ovf;
  logic         clr_err;

  bus_reader #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .bus_en    (bus_en),
    .ld        (ld),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .err_float (err_float),
    .err_ovf   (err_ovf),
    .clr_err   (clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: contents as a plain queue, flags as bits.
  logic [W-1:0] q[$];
  bit           m_float = 0;
  bit           m_ovf   = 0;
  // Values the DUT actually presented when a pop was accepted.
  logic [W-1:0] seen[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("count", 32'(count), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == D));
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    if (q.size() != 0) check("out_data", 32'(out_data), 32'(q[0]));
    check("err_float", 32'(err_float), 32'(m_float));
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
  endtask

  task automatic step(input logic l, input logic e, input logic [W-1:0] b,
                      input logic r, input logic c);
    int  sz;
    bit  pop_ok;
    bit  cap;
    bit  drop;
    ld = l; bus_en = e; bus = b; out_ready = r; clr_err = c;
    if (out_valid && r) seen.push_back(out_data);
    @(posedge clk);
    sz     = q.size();
    pop_ok = (sz > 0) && r;
    cap    = l && e;
    drop   = cap && (sz == D) && !pop_ok;
    if (pop_ok) void'(q.pop_front());
    if (cap && !drop) q.push_back(b);
    m_float = (l && !e) ? 1'b1 : (c ? 1'b0 : m_float);
    m_ovf   = drop      ? 1'b1 : (c ? 1'b0 : m_ovf);
    #1;
    check_model();
  endtask

  initial begin
    logic [W-1:0] exp4[4];
    rst = 1'b1; ld = 0; bus_en = 0; bus = '0; out_ready = 0; clr_err = 0;
    #12;
    check("rst_count", 32'(count), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_full", 32'(full), 0);
    check("rst_errs", 32'({err_float, err_ovf}), 0);
    rst = 1'b0;

    // Single capture, then pop.
    step(1, 1, 8'hAA, 0, 0);
    check("one_valid", 32'(out_valid), 1);
    check("one_data", 32'(out_data), 32'h0AA);
    check("one_count", 32'(count), 1);
    step(0, 0, 8'h00, 1, 0);
    check("one_pop_count", 32'(count), 0);

    // Fill, overflow, drain in order.
    seen.delete();
    step(1, 1, 8'h11, 0, 0);
    step(1, 1, 8'h22, 0, 0);
    step(1, 1, 8'h33, 0, 0);
    step(1, 1, 8'h44, 0, 0);
    check("fill_full", 32'(full), 1);
    check("fill_count", 32'(count), 4);
    step(1, 1, 8'h55, 0, 0);
    check("ovf_set", 32'(err_ovf), 1);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
    exp4 = '{8'h11, 8'h22, 8'h33, 8'h44};
    check("drain_len", 32'(seen.size()), 4);
    for (int i = 0; i < 4; i++) if (i < seen.size()) check("drain_data", 32'(seen[i]), 32'(exp4[i]));

    // Push and pop together while full.
    step(0, 0, 8'h00, 0, 1);
    for (int i = 1; i <= 4; i++) step(1, 1, 8'hA0 + 8'(i), 0, 0);
    seen.delete();
    step(1, 1, 8'h66, 1, 0);
    check("fullpp_count", 32'(count), 4);
    check("fullpp_ovf", 32'(err_ovf), 0);
    for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 1, 0);
    check("fullpp_len", 32'(seen.size()), 5);
    if (seen.size() != 0) check("fullpp_last", 32'(seen[seen.size()-1]), 32'h066);

    // Floating-bus capture and clear priority.
    step(1, 0, 8'hFF, 0, 0);
    check("float_count", 32'(count), 0);
    check("float_set", 32'(err_float), 1);
    step(0, 0, 8'h00, 0, 1);
    check("float_clr", 32'(err_float), 0);
    step(1, 0, 8'hFF, 0, 1);
    check("float_setwins", 32'(err_float), 1);
    step(0, 0, 8'h00, 0, 1);

    // Continuous streaming across pointer wraps.
    seen.delete();
    for (int i = 0; i < 10; i++) step(1, 1, 8'h30 + 8'(i), 1, 0);
    step(0, 0, 8'h00, 1, 0);
    check("stream_len", 32'(seen.size()), 10);
    for (int i = 0; i < 10; i++) if (i < seen.size()) check("stream_data", 32'(seen[i]), 32'h30 + 32'(i));

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) step(1, 1, 8'hC0 + 8'(i), 0, 0);
    check("pre_rst_count", 32'(count), 3);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 0);
    check("arst_valid", 32'(out_valid), 0);
    check("arst_full", 32'(full), 0);
    q.delete(); m_float = 0; m_ovf = 0;
    #2 rst = 1'b0;
    step(1, 1, 8'h04, 0, 0);
    check("post_rst_data", 32'(out_data), 32'h004);
    check("post_rst_count", 32'(count), 1);
    step(0, 0, 8'h00, 1, 0);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 9) < 8), 8'($urandom),
           1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 9) < 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
